// File: rtl/alu_result_stage_pkg.sv
// Shared types for the relay ALU result stage: function codes, condition
// flags and the result-stage state encoding.
package relay_alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_INC = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_CLR = 3'd7
  } alu_fn_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic sign;
  } alu_flags_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DRIVE  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_logic_slice.sv
// Bitwise gate slice of the relay ALU: AND/OR/XOR of B and C plus NOT of B,
// all purely combinational. The adder, rotator and result mux live in the
// result stage itself.
module alu_logic_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] and_out,
  output logic [WIDTH-1:0] or_out,
  output logic [WIDTH-1:0] xor_out,
  output logic [WIDTH-1:0] not_out
);

  assign and_out = b & c;
  assign or_out  = b | c;
  assign xor_out = b ^ c;
  assign not_out = ~b;

endmodule

// File: rtl/alu_result_stage.sv
// Relay ALU result stage. Accepts an operation (fn, b, c) while idle, forms
// the result and zero/carry/sign flags, and holds them on a valid/ack
// handshake until the sequencer takes them.
//
// Build option ALU_SETTLE_EN: when defined, the operands are captured and the
// result is latched only after SETTLE_CYCLES cycles of modelled relay settle
// time. When undefined, the result is latched on the accepting edge and
// presented the following cycle; SETTLE_CYCLES is then unused.
module alu_result_stage
  import relay_alu_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       fn,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ack,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_sign
);

  if (WIDTH < 2) begin : g_bad_width
    $error("alu_result_stage: WIDTH must be at least 2");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("alu_result_stage: SETTLE_CYCLES must be at least 1");
  end

  alu_state_e       state;
  alu_flags_t       flags_q;
  alu_flags_t       nxt_flags;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_carry;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   inc;

  alu_fn_e          src_fn;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] src_c;

  logic [WIDTH-1:0] and_out;
  logic [WIDTH-1:0] or_out;
  logic [WIDTH-1:0] xor_out;
  logic [WIDTH-1:0] not_out;

`ifdef ALU_SETTLE_EN
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;
  alu_fn_e          op_fn;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] op_c;

  // Operand capture on an accepted start; later changes on b/c/fn are ignored.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      op_fn <= alu_fn_e'(fn);
      op_b  <= b;
      op_c  <= c;
    end
  end

  assign src_fn = op_fn;
  assign src_b  = op_b;
  assign src_c  = op_c;
`else
  // Without the settle delay the result is formed straight from the ports
  // and latched on the same edge that accepts the request.
  assign src_fn = alu_fn_e'(fn);
  assign src_b  = b;
  assign src_c  = c;
`endif

  alu_logic_slice #(
    .WIDTH (WIDTH)
  ) u_logic (
    .b       (src_b),
    .c       (src_c),
    .and_out (and_out),
    .or_out  (or_out),
    .xor_out (xor_out),
    .not_out (not_out)
  );

  // Result mux: adder and incrementer carry out of the extra MSB, the
  // shifter is a rotate-left by one, everything else reports carry 0.
  always_comb begin
    sum        = {1'b0, src_b} + {1'b0, src_c};
    inc        = {1'b0, src_b} + {{WIDTH{1'b0}}, 1'b1};
    nxt_result = '0;
    nxt_carry  = 1'b0;
    case (src_fn)
      ALU_ADD: {nxt_carry, nxt_result} = sum;
      ALU_INC: {nxt_carry, nxt_result} = inc;
      ALU_AND: nxt_result = and_out;
      ALU_OR:  nxt_result = or_out;
      ALU_XOR: nxt_result = xor_out;
      ALU_NOT: nxt_result = not_out;
      ALU_SHL: nxt_result = {src_b[WIDTH-2:0], src_b[WIDTH-1]};
      ALU_CLR: nxt_result = '0;
      default: nxt_result = '0;
    endcase
  end

  // Condition flags derived from the selected result.
  always_comb begin
    nxt_flags       = '0;
    nxt_flags.zero  = (nxt_result == '0);
    nxt_flags.carry = nxt_carry;
    nxt_flags.sign  = nxt_result[WIDTH-1];
  end

  // Sequencing FSM: IDLE -> (SETTLE) -> DRIVE -> IDLE, with result latching.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      flags_q      <= '0;
`ifdef ALU_SETTLE_EN
      cnt          <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef ALU_SETTLE_EN
            cnt   <= CNT_W'(SETTLE_CYCLES - 1);
            state <= ST_SETTLE;
`else
            result       <= nxt_result;
            flags_q      <= nxt_flags;
            result_valid <= 1'b1;
            state        <= ST_DRIVE;
`endif
          end
        end
`ifdef ALU_SETTLE_EN
        ST_SETTLE: begin
          if (cnt == '0) begin
            result       <= nxt_result;
            flags_q      <= nxt_flags;
            result_valid <= 1'b1;
            state        <= ST_DRIVE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif
        ST_DRIVE: begin
          // A start arriving with the ack is dropped; the requester retries.
          if (result_ack) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign flag_zero  = flags_q.zero;
  assign flag_carry = flags_q.carry;
  assign flag_sign  = flags_q.sign;

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: directed and randomized operations checked
// against an arithmetic reference model, plus handshake and reset scenarios.
module tb_alu_result_stage;

  localparam int W  = 8;
  localparam int SC = 4;
`ifdef ALU_SETTLE_EN
  localparam int LAT = 1 + SC;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   fn;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         busy;
  logic         result_valid;
  logic         result_ack;
  logic [W-1:0] result;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_sign;

  int n_cmp = 0;
  int n_err = 0;

  alu_result_stage #(
    .WIDTH         (W),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .fn           (fn),
    .b            (b),
    .c            (c),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .result       (result),
    .flag_zero    (flag_zero),
    .flag_carry   (flag_carry),
    .flag_sign    (flag_sign)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: result and carry from the function code with plain
  // integer arithmetic on 8-bit values.
  function automatic void model(input int f, input int bv, input int cv,
                                output logic [7:0] r, output logic [2:0] zcs);
    int s;
    int cy;
    cy = 0;
    case (f)
      0: begin s = bv + cv; r = 8'(s % 256); cy = (s > 255) ? 1 : 0; end
      1: begin s = bv + 1;  r = 8'(s % 256); cy = (s > 255) ? 1 : 0; end
      2: r = 8'(bv & cv);
      3: r = 8'(bv | cv);
      4: r = 8'(bv ^ cv);
      5: r = 8'(255 - bv);
      6: r = 8'(((bv * 2) % 256) + (bv / 128));
      default: r = 8'd0;
    endcase
    zcs = {(r == 8'd0), (cy != 0), (r >= 8'd128)};
  endfunction

  // Issue one operation and wait (bounded) for result_valid. lat is the
  // number of cycles after the start cycle at which valid was first seen.
  task automatic run_op(input logic [2:0] f, input logic [7:0] bv, input logic [7:0] cv,
                        output int lat);
    fn    = f;
    b     = bv;
    c     = cv;
    start = 1'b1;
    step();
    start = 1'b0;
    fn    = 3'($urandom);
    b     = 8'($urandom);
    c     = 8'($urandom);
    lat   = 1;
    while (result_valid !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
  endtask

  task automatic ack_op();
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    fn    = 3'd0;
    b     = 8'h7F;
    c     = 8'h01;
    step();
    step();
    reset = 1'b0;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++;
    if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", result_valid); end
    n_cmp++;
    if (result !== 8'h00) begin n_err++; $display("FAIL reset_result: got %h want 00", result); end
    n_cmp++;
    if ({flag_zero, flag_carry, flag_sign} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {flag_zero, flag_carry, flag_sign});
    end
    step();
    n_cmp++;
    if ({busy, result_valid} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle: busy/valid got %b want 00", {busy, result_valid});
    end
  endtask

  task automatic test_add();
    int lat;
    run_op(3'd0, 8'h7F, 8'h01, lat);
    n_cmp++;
    if (lat != LAT) begin n_err++; $display("FAIL add_latency: got %0d want %0d", lat, LAT); end
    n_cmp++;
    if (result !== 8'h80) begin n_err++; $display("FAIL add_7f_01_result: got %h want 80", result); end
    n_cmp++;
    if ({flag_zero, flag_carry, flag_sign} !== 3'b001) begin
      n_err++; $display("FAIL add_7f_01_flags: got %b want 001", {flag_zero, flag_carry, flag_sign});
    end
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL add_busy: got %b want 1", busy); end
    ack_op();
    n_cmp++;
    if ({busy, result_valid} !== 2'b00) begin
      n_err++; $display("FAIL add_after_ack: busy/valid got %b want 00", {busy, result_valid});
    end

    run_op(3'd0, 8'hFF, 8'h01, lat);
    n_cmp++;
    if ({result, flag_zero, flag_carry, flag_sign} !== {8'h00, 3'b110}) begin
      n_err++; $display("FAIL add_ff_01: got %h/%b want 00/110", result, {flag_zero, flag_carry, flag_sign});
    end
    ack_op();

    run_op(3'd1, 8'hFF, 8'h5C, lat);
    n_cmp++;
    if ({result, flag_zero, flag_carry, flag_sign} !== {8'h00, 3'b110}) begin
      n_err++; $display("FAIL inc_ff: got %h/%b want 00/110", result, {flag_zero, flag_carry, flag_sign});
    end
    ack_op();
  endtask

  task automatic test_logic();
    logic [7:0] exp_tab [6];
    logic [7:0] e;
    int lat;
    exp_tab = '{8'h05, 8'hAF, 8'hAA, 8'h5A, 8'h4B, 8'h00};
    for (int i = 0; i < 6; i++) begin
      run_op(3'(2 + i), 8'hA5, 8'h0F, lat);
      e = exp_tab[i];
      n_cmp++;
      if (result !== e) begin n_err++; $display("FAIL logic_fn%0d_result: got %h want %h", 2 + i, result, e); end
      n_cmp++;
      if ({flag_zero, flag_carry, flag_sign} !== {(e == 8'h00), 1'b0, e[7]}) begin
        n_err++; $display("FAIL logic_fn%0d_flags: got %b want %b", 2 + i,
                          {flag_zero, flag_carry, flag_sign}, {(e == 8'h00), 1'b0, e[7]});
      end
      ack_op();
    end
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic [7:0] bv;
    logic [7:0] cv;
    logic [7:0] er;
    logic [2:0] ef;
    int lat;
    int hold;
    for (int i = 0; i < 40; i++) begin
      f  = 3'($urandom_range(0, 7));
      bv = 8'($urandom);
      cv = 8'($urandom);
      if (i % 8 == 0) bv = 8'hFF;
      model(int'(f), int'(bv), int'(cv), er, ef);
      run_op(f, bv, cv, lat);
      n_cmp++;
      if (lat != LAT) begin n_err++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, LAT); end
      n_cmp++;
      if ({result, flag_zero, flag_carry, flag_sign} !== {er, ef}) begin
        n_err++; $display("FAIL rand%0d fn=%0d b=%h c=%h: got %h/%b want %h/%b", i, f, bv, cv,
                          result, {flag_zero, flag_carry, flag_sign}, er, ef);
      end
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) step();
      n_cmp++;
      if ({result_valid, result} !== {1'b1, er}) begin
        n_err++; $display("FAIL rand%0d_hold: valid/result got %b/%h want 1/%h", i, result_valid, result, er);
      end
      ack_op();
      n_cmp++;
      if ({busy, result_valid} !== 2'b00) begin
        n_err++; $display("FAIL rand%0d_ack: busy/valid got %b want 00", i, {busy, result_valid});
      end
    end
  endtask

  task automatic test_handshake();
    int lat;
    fn    = 3'd0;
    b     = 8'h10;
    c     = 8'h20;
    start = 1'b1;
    step();
    // Keep requesting a different operation while the first one is in flight.
    fn = 3'd7;
    b  = 8'hFF;
    c  = 8'hFF;
    lat = 1;
    while (result_valid !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
    n_cmp++;
    if (lat != LAT) begin n_err++; $display("FAIL hs_latency: got %0d want %0d", lat, LAT); end
    n_cmp++;
    if (result !== 8'h30) begin n_err++; $display("FAIL hs_start_ignored: got %h want 30", result); end
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if ({result_valid, busy, result, flag_zero, flag_carry, flag_sign} !== {2'b11, 8'h30, 3'b000}) begin
        n_err++; $display("FAIL hs_hold%0d: valid/busy/result/flags got %b%b/%h/%b want 11/30/000", k,
                          result_valid, busy, result, {flag_zero, flag_carry, flag_sign});
      end
    end
    result_ack = 1'b1;
    step();
    result_ack = 1'b0;
    start      = 1'b0;
    n_cmp++;
    if ({busy, result_valid} !== 2'b00) begin
      n_err++; $display("FAIL hs_ack_start: busy/valid got %b want 00", {busy, result_valid});
    end
    for (int k = 0; k < LAT + 2; k++) begin
      result_ack = 1'b1;
      step();
      result_ack = 1'b0;
      n_cmp++;
      if ({busy, result_valid} !== 2'b00) begin
        n_err++; $display("FAIL hs_no_new_op%0d: busy/valid got %b want 00", k, {busy, result_valid});
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    fn    = 3'd0;
    b     = 8'h33;
    c     = 8'h44;
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy: got %b want 1", busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++;
    if ({busy, result_valid, result, flag_zero, flag_carry, flag_sign} !== 13'd0) begin
      n_err++; $display("FAIL rmid_clear: busy/valid/result/flags got %b%b/%h/%b want 00/00/000",
                        busy, result_valid, result, {flag_zero, flag_carry, flag_sign});
    end
    for (int k = 0; k < LAT + 2; k++) step();
    n_cmp++;
    if ({busy, result_valid} !== 2'b00) begin
      n_err++; $display("FAIL rmid_discarded: busy/valid got %b want 00", {busy, result_valid});
    end
    run_op(3'd0, 8'h12, 8'h34, lat);
    n_cmp++;
    if (lat != LAT) begin n_err++; $display("FAIL rmid_new_latency: got %0d want %0d", lat, LAT); end
    n_cmp++;
    if ({result, flag_zero, flag_carry, flag_sign} !== {8'h46, 3'b000}) begin
      n_err++; $display("FAIL rmid_new_result: got %h/%b want 46/000", result, {flag_zero, flag_carry, flag_sign});
    end
    ack_op();
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    result_ack = 1'b0;
    fn         = 3'd0;
    b          = '0;
    c          = '0;
    test_reset();
    test_add();
    test_logic();
    test_random();
    test_handshake();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
